// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store port bundle between the CPU mem stage and the data memory
//
// Purpose: groups the request, response and stall signals of one data-memory port.
// Signals:
//   req_valid  master->slave  access request present
//   req_we     master->slave  1 = store, 0 = load
//   req_be     master->slave  store byte enables, bit i -> req_wdata[8i+7:8i]
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  store data
//   req_ready  slave->master  request can be accepted this cycle
//   resp_valid slave->master  one-cycle completion pulse
//   resp_rdata slave->master  load data, valid with resp_valid
//   resp_err   slave->master  access rejected, valid with resp_valid
//   stall_o    slave->master  hold the pipeline while an access is pending
// Modports: master (CPU side), slave (memory side).

interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall_o;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall_o
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall_o
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory answering one load/store at a time
//
// Purpose: far end of the mem-stage load/store port. Accepts one request in IDLE,
// waits WAIT_CYC cycles, then commits (store writes enabled bytes / load registers
// the word) on the edge entering RESP and pulses resp_valid for one cycle.
// Misaligned or out-of-range accesses complete with resp_err=1, no write, rdata=0.
// Parameters:
//   AW_WORDS  log2 of storage depth in 32-bit words
//   WAIT_CYC  wait cycles between acceptance and response (0..15)
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset (storage itself is not cleared)
//   bus  slave modport of dmem_responder_if (request, response, stall)

module dmem_responder #(
  parameter int AW_WORDS = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic [31:0] r_mem [0:(1 << AW_WORDS) - 1];

  logic                w_take_now;
  logic                w_wait_done;
  logic                w_commit;
  logic                w_we;
  logic [3:0]          w_be;
  logic [31:0]         w_addr;
  logic [31:0]         w_wdata;
  logic                w_err;
  logic [AW_WORDS-1:0] w_idx;

  // With no wait cycles the commit happens on the accepting edge itself, so the
  // live request is used; otherwise the latched copy is.
  assign w_take_now  = (r_state == S_IDLE) && bus.req_valid && (WAIT_CYC == 0);
  assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 4'd0);
  // rst gates the commit so the (unreset) storage cannot be written while reset is held.
  assign w_commit    = rst && (w_take_now || w_wait_done);

  assign w_we    = (r_state == S_IDLE) ? bus.req_we    : r_we;
  assign w_be    = (r_state == S_IDLE) ? bus.req_be    : r_be;
  assign w_addr  = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;

  assign w_err = (w_addr[1:0] != 2'b00) || ((w_addr >> (AW_WORDS + 2)) != 32'd0);
  assign w_idx = w_addr[AW_WORDS+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_be         <= 4'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_commit;
      if (w_commit) begin
        r_resp_err   <= w_err;
        r_resp_rdata <= (w_we || w_err) ? 32'd0 : r_mem[w_idx];
      end

      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_be    <= bus.req_be;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            if (WAIT_CYC == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage has no reset: contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.stall_o    = ((r_state == S_IDLE) && bus.req_valid) || (r_state == S_WAIT);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (WAIT_CYC=1 and WAIT_CYC=0 builds)

module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  dmem_responder_if if_a ();
  dmem_responder_if if_b ();

  dmem_responder #(.AW_WORDS(10), .WAIT_CYC(1)) u_dut_w1 (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  dmem_responder #(.AW_WORDS(10), .WAIT_CYC(0)) u_dut_w0 (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  // index 0 -> WAIT_CYC=1 build, index 1 -> WAIT_CYC=0 build
  logic        t_valid [2];
  logic        t_we    [2];
  logic [3:0]  t_be    [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];

  logic        o_rdy   [2];
  logic        o_rv    [2];
  logic [31:0] o_rdata [2];
  logic        o_err   [2];
  logic        o_stall [2];

  assign if_a.req_valid = t_valid[0];
  assign if_a.req_we    = t_we[0];
  assign if_a.req_be    = t_be[0];
  assign if_a.req_addr  = t_addr[0];
  assign if_a.req_wdata = t_wdata[0];
  assign if_b.req_valid = t_valid[1];
  assign if_b.req_we    = t_we[1];
  assign if_b.req_be    = t_be[1];
  assign if_b.req_addr  = t_addr[1];
  assign if_b.req_wdata = t_wdata[1];

  assign o_rdy[0]   = if_a.req_ready;
  assign o_rv[0]    = if_a.resp_valid;
  assign o_rdata[0] = if_a.resp_rdata;
  assign o_err[0]   = if_a.resp_err;
  assign o_stall[0] = if_a.stall_o;
  assign o_rdy[1]   = if_b.req_ready;
  assign o_rv[1]    = if_b.resp_valid;
  assign o_rdata[1] = if_b.resp_rdata;
  assign o_err[1]   = if_b.resp_err;
  assign o_stall[1] = if_b.stall_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference memory: key = build*4096 + word index, holds only words ever stored.
  logic [31:0] mdl [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_err(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= 32'h0000_1000);
  endfunction

  function automatic int mkey(input int sel, input logic [31:0] addr);
    return sel * 4096 + int'(addr / 4);
  endfunction

  // One complete access, starting and ending on a falling edge with the DUT idle.
  task automatic access(input int sel, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          k;
    int          wc;
    logic        err;
    logic [31:0] exp_rd;
    logic [31:0] word;
    wc  = (sel == 0) ? 1 : 0;
    err = addr_err(addr);
    exp_rd = 32'd0;
    if (!we && !err && mdl.exists(mkey(sel, addr))) exp_rd = mdl[mkey(sel, addr)];

    @(negedge clk);
    t_valid[sel] = 1'b1;
    t_we[sel]    = we;
    t_be[sel]    = be;
    t_addr[sel]  = addr;
    t_wdata[sel] = wdata;
    #1;
    check("accept_ready", 32'(o_rdy[sel]), 32'd1);
    check("accept_stall", 32'(o_stall[sel]), 32'd1);

    @(negedge clk);
    // scramble the request after acceptance; it must not matter
    t_valid[sel] = 1'b0;
    t_we[sel]    = 1'($urandom);
    t_be[sel]    = 4'($urandom);
    t_addr[sel]  = $urandom;
    t_wdata[sel] = $urandom;
    k = 1;
    while (o_rv[sel] !== 1'b1 && k < 20) begin
      check("wait_stall", 32'(o_stall[sel]), 32'd1);
      check("wait_ready", 32'(o_rdy[sel]), 32'd0);
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(wc + 1));
    check("resp_valid", 32'(o_rv[sel]), 32'd1);
    check("resp_stall", 32'(o_stall[sel]), 32'd0);
    check("resp_ready", 32'(o_rdy[sel]), 32'd0);
    check("resp_err", 32'(o_err[sel]), 32'(err));
    check("resp_rdata", o_rdata[sel], exp_rd);

    if (we && !err) begin
      word = mdl.exists(mkey(sel, addr)) ? mdl[mkey(sel, addr)] : 32'd0;
      for (int i = 0; i < 4; i++)
        if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
      mdl[mkey(sel, addr)] = word;
    end

    t_valid[sel] = 1'b0;
    @(negedge clk);
    check("pulse_end", 32'(o_rv[sel]), 32'd0);
    check("idle_ready", 32'(o_rdy[sel]), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    int          s;

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      t_valid[i] = 1'b0; t_we[i] = 1'b0; t_be[i] = 4'd0;
      t_addr[i] = 32'd0; t_wdata[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_valid", 32'(o_rv[i]), 32'd0);
      check("rst_rdata", o_rdata[i], 32'd0);
      check("rst_err", 32'(o_err[i]), 32'd0);
      check("rst_ready", 32'(o_rdy[i]), 32'd1);
      check("rst_stall", 32'(o_stall[i]), 32'd0);
    end
    rst = 1'b1;

    // full-word store then load, WAIT_CYC=1
    access(0, 1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF);
    access(0, 1'b0, 4'h0, 32'h40, 32'h0);

    // byte lanes merge into the existing word
    access(0, 1'b1, 4'b0001, 32'h40, 32'h0000_00AA);
    access(0, 1'b1, 4'b0100, 32'h40, 32'h00CC_0000);
    access(0, 1'b1, 4'b0000, 32'h40, 32'hFFFF_FFFF);
    access(0, 1'b0, 4'h0, 32'h40, 32'h0);

    // misaligned load, out-of-range store aliasing word 0
    access(0, 1'b0, 4'h0, 32'h42, 32'h0);
    access(0, 1'b1, 4'hF, 32'h0, 32'h0BAD_F00D);
    access(0, 1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF);
    access(0, 1'b0, 4'h0, 32'h0, 32'h0);

    // request held continuously: one accept every 3 cycles
    @(negedge clk);
    t_valid[0] = 1'b1; t_we[0] = 1'b0; t_be[0] = 4'h0; t_addr[0] = 32'h40;
    #1;
    for (int k = 0; k < 9; k++) begin
      check("hold_stall", 32'(o_stall[0]), 32'((k % 3) != 2));
      check("hold_ready", 32'(o_rdy[0]), 32'((k % 3) == 0));
      check("hold_valid", 32'(o_rv[0]), 32'((k % 3) == 2));
      if ((k % 3) == 2) check("hold_rdata", o_rdata[0], mdl[mkey(0, 32'h40)]);
      @(negedge clk);
      #1;
    end
    t_valid[0] = 1'b0;

    // WAIT_CYC=0 build
    access(1, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D);
    access(1, 1'b0, 4'h0, 32'h40, 32'h0);
    access(1, 1'b0, 4'h0, 32'h43, 32'h0);

    // reset mid-WAIT drops the pending store
    access(0, 1'b1, 4'hF, 32'h10, 32'h1122_3344);
    @(negedge clk);
    t_valid[0] = 1'b1; t_we[0] = 1'b1; t_be[0] = 4'hF;
    t_addr[0] = 32'h10; t_wdata[0] = 32'hBADB_AD00;
    @(negedge clk);
    t_valid[0] = 1'b0;
    check("pre_abort_stall", 32'(o_stall[0]), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_valid", 32'(o_rv[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid_post", 32'(o_rv[0]), 32'd0);
    check("abort_ready", 32'(o_rdy[0]), 32'd1);
    check("abort_stall", 32'(o_stall[0]), 32'd0);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0);

    // randomized traffic on both builds against the reference memory
    for (int s0 = 0; s0 < 2; s0++)
      for (int i = 0; i < 8; i++)
        access(s0, 1'b1, 4'hF, 32'h100 + 32'(4 * i), $urandom);
    for (int n = 0; n < 60; n++) begin
      s = int'($urandom % 2);
      r = int'($urandom % 8);
      if (r == 0)      a = 32'h100 + 32'(4 * ($urandom % 8)) + 32'(1 + $urandom % 3);
      else if (r == 1) a = 32'h1000 + 32'(4 * ($urandom % 256));
      else             a = 32'h100 + 32'(4 * ($urandom % 8));
      access(s, 1'($urandom), 4'($urandom), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
